// File: rtl/spi_pkg.sv
// Shared definitions for the duplex SPI slave: FSM encoding, mode field
// positions, frame-length limits and the frame-length clamp helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_WAIT_DESEL = 2'd2
  } spi_state_e;

  // Bit positions inside the 2-bit mode word {CPOL, CPHA}.
  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  // Legal range of the MAX_BYTES parameter.
  localparam int MAX_BYTES_LO = 1;
  localparam int MAX_BYTES_HI = 8;

  // Effective frame length in bytes: 0 or anything above the maximum
  // selects the maximum.
  function automatic logic [3:0] frame_len(input logic [3:0] byte_count,
                                           input logic [3:0] max_bytes);
    if (byte_count == 4'd0 || byte_count > max_bytes) return max_bytes;
    return byte_count;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input plus rise/fall strobes
// taken from the last two stages. level_o is the oldest (most settled) stage.
module spi_sync_edge #(
  parameter int   STAGES    = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain.
  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RESET_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall_o  = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave, all four modes, 1..MAX_BYTES byte frames, running
// entirely in the CLK domain with oversampled SCK/CSEL/MOSI.
module spi_slave_duplex
  import spi_pkg::*;
#(
  parameter int MAX_BYTES   = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SCK,
  input  logic                   CSEL,
  input  logic                   MOSI,
  output logic                   MISO,
  input  logic [1:0]             mode,
  input  logic [3:0]             byte_count,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   busy,
  output logic                   aborted,
  output logic                   underrun
);

  localparam int W  = 8 * MAX_BYTES;
  localparam int IW = $clog2(W);
  localparam int MAX_B_INT = (MAX_BYTES < MAX_BYTES_LO) ? MAX_BYTES_LO :
                             ((MAX_BYTES > MAX_BYTES_HI) ? MAX_BYTES_HI : MAX_BYTES);
  localparam logic [3:0] MAX_B = 4'(MAX_B_INT);

  // Synchronised inputs and strobes.
  logic sck_level, sck_rise, sck_fall;
  logic csel_level, csel_rise, csel_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk     (CLK),
    .rst     (RST),
    .d_i     (SCK),
    .level_o (sck_level),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csel (
    .clk     (CLK),
    .rst     (RST),
    .d_i     (CSEL),
    .level_o (csel_level),
    .rise_o  (csel_rise),
    .fall_o  (csel_fall)
  );

  // MOSI takes the same path length as SCK so the oldest stage holds the
  // data as it was just before the detected SCK edge.
  always_ff @(posedge CLK) begin
    if (RST) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Registers.
  spi_state_e        state_q, state_d;
  logic [1:0]        mode_q;
  logic [IW-1:0]     bit_cnt_q;
  logic [IW-1:0]     tx_idx_q;
  logic              tx_en_q;
  logic [W-1:0]      tx_sr_q;
  logic [W-2:0]      rx_sr_q;
  logic [W-1:0]      hold_q;
  logic              hold_valid_q;
  logic [W-1:0]      rx_data_q;
  logic              rx_valid_q, aborted_q, underrun_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic              armed_q;

  // Edge classification from the latched mode. sck_level is the pre-edge
  // level, so an edge leaving the idle level (CPOL) is the leading edge.
  logic sck_edge, leading, trailing, sample_edge, drive_edge;
  assign sck_edge    = sck_rise | sck_fall;
  assign leading     = sck_edge & (sck_level == mode_q[MODE_CPOL]);
  assign trailing    = sck_edge & (sck_level != mode_q[MODE_CPOL]);
  assign sample_edge = mode_q[MODE_CPHA] ? trailing : leading;
  assign drive_edge  = mode_q[MODE_CPHA] ? leading  : trailing;

  logic [IW-1:0] nbits_start;
  assign nbits_start = IW'({frame_len(byte_count, MAX_B), 3'b000} - 7'd1);

  logic tx_load;
  assign tx_ready = (state_q == ST_IDLE) && !hold_valid_q;
  assign tx_load  = tx_valid && tx_ready;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and per-cycle datapath controls.
  logic start, sample_en, drive_en, finish, abort;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    state_d   = state_q;
    start     = 1'b0;
    sample_en = 1'b0;
    drive_en  = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csel_fall && armed_q) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (csel_rise) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (sample_edge) begin
          sample_en = 1'b1;
          if (bit_cnt_q == '0) begin
            finish  = 1'b1;
            state_d = ST_WAIT_DESEL;
          end
        end else if (drive_edge) begin
          drive_en = 1'b1;
        end
      end
      ST_WAIT_DESEL: begin
        if (csel_level) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // After reset the CSEL synchroniser still holds its preload; only arm
  // frame detection once it carries real samples and CSEL is seen high,
  // so a frame already running at reset release is ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      if (flush_q[SYNC_STAGES-1] && csel_level) armed_q <= 1'b1;
    end
  end

  // Holder, shift registers, counters, received word and status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q       <= '0;
      bit_cnt_q    <= '0;
      tx_idx_q     <= '0;
      tx_en_q      <= 1'b0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      aborted_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      aborted_q  <= 1'b0;
      underrun_q <= 1'b0;

      if (tx_load) begin
        hold_q       <= tx_data;
        hold_valid_q <= 1'b1;
      end

      if (start) begin
        // A load in the same cycle bypasses the holder into this frame.
        mode_q       <= mode;
        bit_cnt_q    <= nbits_start;
        tx_idx_q     <= nbits_start;
        tx_en_q      <= ~mode[MODE_CPHA];
        tx_sr_q      <= tx_load ? tx_data : (hold_valid_q ? hold_q : '0);
        underrun_q   <= !(tx_load || hold_valid_q);
        hold_q       <= '0;
        hold_valid_q <= 1'b0;
        rx_sr_q      <= '0;
      end

      if (sample_en) begin
        rx_sr_q <= {rx_sr_q[W-3:0], mosi_s};
        if (!finish) bit_cnt_q <= bit_cnt_q - IW'(1);
      end

      if (finish) begin
        rx_data_q  <= {rx_sr_q, mosi_s};
        rx_valid_q <= 1'b1;
      end

      // With CPHA=1 the first drive edge only enables the MSB.
      if (drive_en) begin
        if (!tx_en_q)              tx_en_q  <= 1'b1;
        else if (tx_idx_q != '0)   tx_idx_q <= tx_idx_q - IW'(1);
      end

      if (abort) aborted_q <= 1'b1;
    end
  end

  assign MISO     = (state_q == ST_SHIFT) & tx_en_q & tx_sr_q[tx_idx_q] & ~CSEL;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign aborted  = aborted_q;
  assign underrun = underrun_q;

endmodule
